// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, requests words from instruction memory,
// and is the only writer of the IF/ID latch. Static predict-not-taken; EX redirects
// override the PC, and a word that arrives while decode is stalled is parked locally.
module fetch_unit #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    output logic             iREN,
    output logic [31:0]      iaddr,
    input  logic             ihit,
    input  logic [31:0]      iload,
    input  logic             stall,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_pc,
    input  logic             halt,
    output logic             ifid_wen,
    output logic             ifid_flush,
    output logic [31:0]      instr_in,
    output logic [31:0]      pcplus4_in,
    output logic [31:0]      next_pc_in,
    output logic [CNT_W-1:0] fetch_cnt
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HOLD   = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc;
    logic [31:0] hold_buf;
    logic [31:0] hold_pc;
    logic [31:0] pc_plus4;
    logic [31:0] hold_plus4;
    logic        capture;
    logic        take_redirect;

    // Wraps modulo 2^32 naturally.
    assign pc_plus4   = pc + 32'd4;
    assign hold_plus4 = hold_pc + 32'd4;
    assign iaddr      = pc;

    // Halt outranks a redirect; nothing redirects once halted.
    assign take_redirect = redirect_valid && !halt && (state != HALTED);

    // State register.
    always_ff @(posedge CLK) begin
        if (!nRST) state <= RUN;
        else       state <= state_next;
    end

    // Next-state selection and the decision to park a stalled word.
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        case (state)
            RUN: begin
                if (halt)                state_next = HALTED;
                else if (redirect_valid) state_next = RUN;
                else if (ihit && stall) begin
                    state_next = HOLD;
                    capture    = 1'b1;
                end
            end
            HOLD: begin
                if (halt)                state_next = HALTED;
                else if (redirect_valid) state_next = RUN;
                else if (!stall)         state_next = RUN;
            end
            HALTED:  state_next = HALTED;
            default: state_next = RUN;
        endcase
    end

    // IF/ID and imem control outputs; reset forces a flush with zeroed data.
    always_comb begin
        iREN       = 1'b0;
        ifid_wen   = 1'b0;
        ifid_flush = 1'b0;
        instr_in   = '0;
        pcplus4_in = '0;
        next_pc_in = '0;
        if (!nRST) begin
            ifid_flush = 1'b1;
        end else begin
            case (state)
                RUN: begin
                    iREN       = 1'b1;
                    instr_in   = iload;
                    pcplus4_in = pc_plus4;
                    next_pc_in = pc_plus4;
                    ifid_wen   = ihit && !stall && !halt && !redirect_valid;
                    ifid_flush = take_redirect;
                end
                HOLD: begin
                    instr_in   = hold_buf;
                    pcplus4_in = hold_plus4;
                    next_pc_in = hold_plus4;
                    ifid_wen   = !stall && !halt && !redirect_valid;
                    ifid_flush = take_redirect;
                end
                default: ;
            endcase
        end
    end

    // PC, parked word and retired-fetch counter.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            pc        <= PC_INIT & ~32'd3;
            hold_buf  <= '0;
            hold_pc   <= '0;
            fetch_cnt <= '0;
        end else begin
            if (take_redirect) begin
                pc <= redirect_pc & ~32'd3;
            end else if (ifid_wen) begin
                pc        <= pc_plus4;
                fetch_cnt <= fetch_cnt + CNT_W'(1);
            end
            if (capture) begin
                hold_buf <= iload;
                hold_pc  <= pc;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: words expected in IF/ID are queued when the
// memory delivers them and checked when the unit writes IF/ID.
module tb_fetch_unit;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        ihit;
    logic [31:0] iload;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;

    logic        iREN, ifid_wen, ifid_flush;
    logic [31:0] iaddr, instr_in, pcplus4_in, next_pc_in;
    logic [31:0] fetch_cnt;

    logic        w_iREN, w_wen, w_flush;
    logic [31:0] w_iaddr, w_instr, w_p4, w_next, w_cnt;

    int total = 0;
    int bad   = 0;
    logic [63:0] sb[$];

    always #5 CLK = ~CLK;

    fetch_unit #(.PC_INIT(32'h0000_0000), .CNT_W(32)) u_dut (
        .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .ihit(ihit),
        .iload(iload), .stall(stall), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .halt(halt), .ifid_wen(ifid_wen),
        .ifid_flush(ifid_flush), .instr_in(instr_in), .pcplus4_in(pcplus4_in),
        .next_pc_in(next_pc_in), .fetch_cnt(fetch_cnt)
    );

    fetch_unit #(.PC_INIT(32'hFFFF_FFFC), .CNT_W(32)) u_wrap (
        .CLK(CLK), .nRST(nRST), .iREN(w_iREN), .iaddr(w_iaddr), .ihit(ihit),
        .iload(iload), .stall(stall), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .halt(halt), .ifid_wen(w_wen),
        .ifid_flush(w_flush), .instr_in(w_instr), .pcplus4_in(w_p4),
        .next_pc_in(w_next), .fetch_cnt(w_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] word, input logic [31:0] p4);
        sb.push_back({word, p4});
    endtask

    // Drive one cycle, check control outputs mid-cycle, score any IF/ID write.
    task automatic step(input string tag, input logic h, input logic [31:0] ld,
                        input logic st, input logic rv, input logic [31:0] rpc,
                        input logic hl, input logic e_wen, input logic e_flush,
                        input logic e_iren, input logic [31:0] e_iaddr);
        logic [63:0] item;
        ihit = h; iload = ld; stall = st;
        redirect_valid = rv; redirect_pc = rpc; halt = hl;
        #3;
        chk({tag, ".wen"},   {31'd0, ifid_wen},   {31'd0, e_wen});
        chk({tag, ".flush"}, {31'd0, ifid_flush}, {31'd0, e_flush});
        chk({tag, ".iren"},  {31'd0, iREN},       {31'd0, e_iren});
        chk({tag, ".iaddr"}, iaddr, e_iaddr);
        if (ifid_wen === 1'b1) begin
            if (sb.size() == 0) begin
                chk({tag, ".sb_unexpected_write"}, instr_in, 32'hxxxx_xxxx);
            end else begin
                item = sb.pop_front();
                chk({tag, ".instr"},   instr_in,   item[63:32]);
                chk({tag, ".pcplus4"}, pcplus4_in, item[31:0]);
                chk({tag, ".next_pc"}, next_pc_in, item[31:0]);
            end
        end
        @(posedge CLK);
        #1;
    endtask

    initial begin
        nRST = 1'b0; ihit = 1'b0; iload = 32'hDEAD_BEEF; stall = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0; halt = 1'b0;
        #1;
        // Reset: outputs forced even though iload is non-zero.
        chk("rst.instr", instr_in, 32'h0);
        chk("rst.p4", pcplus4_in, 32'h0);
        step("rst0", 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hxxxx_xxxx);
        chk("rst.cnt", fetch_cnt, 32'd0);
        chk("rst.pc", iaddr, 32'd0);
        chk("rst.wrap_pc", w_iaddr, 32'hFFFF_FFFC);
        nRST = 1'b1;

        // Streaming fetch with zero-latency commit; wrap instance checked alongside.
        ihit = 1'b1; iload = 32'hA000_0001; #3;
        chk("wrap.p4", w_p4, 32'h0);
        chk("wrap.next", w_next, 32'h0);
        chk("wrap.wen", {31'd0, w_wen}, 32'd1);
        #1;
        push(32'hA000_0001, 32'd4);
        step("run0", 1'b1, 32'hA000_0001, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 32'd0);
        chk("wrap.pc", w_iaddr, 32'h0);
        push(32'hB000_0002, 32'd8);
        step("run1", 1'b1, 32'hB000_0002, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 32'd4);
        push(32'hC000_0003, 32'd12);
        step("run2", 1'b1, 32'hC000_0003, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 32'd8);
        chk("run.pc", iaddr, 32'd12);
        chk("run.cnt", fetch_cnt, 32'd3);
        step("miss", 1'b0, 32'h0BAD_0BAD, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd12);

        // Stall while a word arrives: parked, then released once.
        push(32'h2000_0005, 32'd16);
        step("cap", 1'b1, 32'h2000_0005, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd12);
        step("hold", 1'b1, 32'h0BAD_0001, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd12);
        step("rel", 1'b0, 32'h0BAD_0002, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd12);
        chk("rel.pc", iaddr, 32'd16);
        chk("rel.cnt", fetch_cnt, 32'd4);

        // Redirect while holding: flush, aligned target, parked word dropped.
        step("cap2", 1'b1, 32'h1111_1111, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd16);
        step("hold_rd", 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0103, 1'b0, 1'b0, 1'b1, 1'b0, 32'd16);
        chk("hold_rd.pc", iaddr, 32'h0000_0100);
        chk("hold_rd.cnt", fetch_cnt, 32'd4);
        step("post_rd", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h100);

        // Redirect and hit together: hit discarded.
        step("rd_hit", 1'b1, 32'h2222_2222, 1'b0, 1'b1, 32'h0000_0200, 1'b0, 1'b0, 1'b1, 1'b1, 32'h100);
        chk("rd_hit.pc", iaddr, 32'h200);
        chk("rd_hit.cnt", fetch_cnt, 32'd4);
        push(32'h3333_3333, 32'h204);
        step("after_rd", 1'b1, 32'h3333_3333, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h200);
        chk("after_rd.cnt", fetch_cnt, 32'd5);

        // Halt beats redirect; stays halted until reset.
        step("halt", 1'b1, 32'h4444_4444, 1'b0, 1'b1, 32'h400, 1'b1, 1'b0, 1'b0, 1'b1, 32'h204);
        step("halted0", 1'b1, 32'h4444_4444, 1'b0, 1'b1, 32'h400, 1'b0, 1'b0, 1'b0, 1'b0, 32'h204);
        step("halted1", 1'b1, 32'h4444_4444, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h204);
        chk("halted.cnt", fetch_cnt, 32'd5);
        nRST = 1'b0;
        step("rst1", 1'b1, 32'h4444_4444, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h204);
        chk("rst1.pc", iaddr, 32'd0);
        chk("rst1.cnt", fetch_cnt, 32'd0);
        nRST = 1'b1;
        push(32'h5555_5555, 32'd4);
        step("restart", 1'b1, 32'h5555_5555, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 32'd0);
        chk("restart.cnt", fetch_cnt, 32'd1);

        chk("sb.empty", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
